// File: rtl/xctcmsg_receive_matcher.sv
// Receive matcher: buffers incoming network messages in age order and serves receive-queue
// requests (blocking receive or availability probe) by masked {tag,address} match.
//
// state | meaning
// IDLE  | waiting for a receive-queue request
// MATCH | comparing the latched request against buffered messages
// RESP  | presenting the writeback result
module xctcmsg_receive_matcher #(
    parameter int DEPTH = 4,
    parameter int PT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                net_valid_i,
    output logic                net_ready_o,
    input  logic [127:0]        net_data_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [128+PT_W:0]   req_data_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [63+PT_W:0]    wb_data_o
);

    localparam int RW = 129 + PT_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, MATCH, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d, ins_pos;
    logic [63:0]    key_q [DEPTH];
    logic [63:0]    dat_q [DEPTH];
    logic [63:0]    key_d [DEPTH];
    logic [63:0]    dat_d [DEPTH];
    logic [RW-1:0]  req_q;
    logic [63:0]    value_q, value_d;
    logic           value_en, rm_en, hit, net_fire, req_fire;
    logic [IW-1:0]  hit_idx;
    logic           req_avail;
    logic [63:0]    req_meta, req_mask;
    logic [PT_W-1:0] req_pt;

    assign req_avail = req_q[RW-1];
    assign req_meta  = req_q[RW-2 -: 64];
    assign req_mask  = req_q[RW-66 -: 64];
    assign req_pt    = req_q[PT_W-1:0];

    // Registered count only: a same-cycle removal never opens a slot early.
    assign net_ready_o = (count_q < CW'(DEPTH));
    assign net_fire    = net_valid_i & net_ready_o;
    assign req_ready_o = (state_q == IDLE);
    assign req_fire    = req_valid_i & req_ready_o;
    assign wb_valid_o  = (state_q == RESP);
    assign wb_data_o   = {value_q, req_pt};

    // Scan from the youngest down so the oldest hit wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (k < int'(count_q) && ((key_q[k] ^ req_meta) & req_mask) == 64'd0) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rm_en    = 1'b0;
        value_en = 1'b0;
        value_d  = value_q;
        case (state_q)
            IDLE: begin
                if (req_fire) state_d = MATCH;
            end
            MATCH: begin
                if (req_avail) begin
                    value_d  = {63'd0, hit};
                    value_en = 1'b1;
                    state_d  = RESP;
                end else if (hit) begin
                    value_d  = dat_q[hit_idx];
                    value_en = 1'b1;
                    rm_en    = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Removal shifts younger entries down; a concurrent insert lands after the shift.
    always_comb begin
        ins_pos = rm_en ? (count_q - CW'(1)) : count_q;
        count_d = count_q + CW'(net_fire) - CW'(rm_en);
        for (int i = 0; i < DEPTH; i++) begin
            key_d[i] = key_q[i];
            dat_d[i] = dat_q[i];
            if (rm_en && i >= int'(hit_idx)) begin
                key_d[i] = key_q[(i < DEPTH - 1) ? i + 1 : i];
                dat_d[i] = dat_q[(i < DEPTH - 1) ? i + 1 : i];
            end
            if (net_fire && i == int'(ins_pos)) begin
                key_d[i] = net_data_i[127:64];
                dat_d[i] = net_data_i[63:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            req_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (req_fire) req_q <= req_data_i;
            if (value_en) value_q <= value_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            key_q[i] <= key_d[i];
            dat_q[i] <= dat_d[i];
        end
    end

endmodule

// File: tb/tb_xctcmsg_receive_matcher.sv
// Bench for xctcmsg_receive_matcher: directed scenarios plus randomized traffic checked
// against a queue-based reference of the message buffer.
module tb_xctcmsg_receive_matcher;

    localparam int DEPTH = 4;
    localparam int PT_W  = 16;
    localparam int RW    = 129 + PT_W;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               net_valid_i;
    logic               net_ready_o;
    logic [127:0]       net_data_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [RW-1:0]      req_data_i;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [63+PT_W:0]   wb_data_o;

    xctcmsg_receive_matcher #(.DEPTH(DEPTH), .PT_W(PT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .net_valid_i (net_valid_i),
        .net_ready_o (net_ready_o),
        .net_data_i  (net_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_data_o   (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] m_key[$];
    logic [63:0] m_dat[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int m_find(input logic [63:0] meta, input logic [63:0] mask);
        for (int i = 0; i < m_key.size(); i++)
            if ((m_key[i] & mask) == (meta & mask)) return i;
        return -1;
    endfunction

    function automatic logic [63:0] mk_key(input int tag, input int addr);
        return {32'(tag), 32'(addr)};
    endfunction

    task automatic send_msg(input logic [63:0] key, input logic [63:0] dat);
        net_valid_i = 1'b1;
        net_data_i  = {key, dat};
        check("net_ready_send", net_ready_o, m_key.size() < DEPTH);
        tick();
        net_valid_i = 1'b0;
        m_key.push_back(key);
        m_dat.push_back(dat);
    endtask

    // gap: cycles to wait before supplying a matching message when the receive blocks.
    task automatic do_recv(input bit avail, input logic [63:0] meta, input logic [63:0] mask,
                           input int gap, input bit ins_in_match);
        logic [PT_W-1:0] pt;
        logic [63:0]     expv;
        logic [63:0]     ikey, idat;
        int              idx;
        bit              acc;
        pt = PT_W'($urandom);
        if (!avail && m_find(meta, mask) < 0 && m_key.size() == DEPTH) avail = 1'b1;
        req_valid_i = 1'b1;
        req_data_i  = {avail, meta, mask, pt};
        check("req_ready_idle", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0;
        check("wb_not_early", wb_valid_o, 1'b0);
        idx = m_find(meta, mask);
        if (!avail && idx < 0) begin
            for (int c = 0; c < gap; c++) begin
                tick();
                check("wb_blocked", wb_valid_o, 1'b0);
                check("req_ready_busy", req_ready_o, 1'b0);
            end
            send_msg(meta, 64'($urandom) << 8 | 64'hE5);
            check("wb_not_early_ins", wb_valid_o, 1'b0);
            idx = m_find(meta, mask);
        end
        if (avail) expv = (idx >= 0) ? 64'd1 : 64'd0;
        else expv = m_dat[idx];
        acc = 1'b0;
        ikey = mk_key($urandom_range(0, 3), $urandom_range(0, 1));
        idat = {$urandom, $urandom};
        if (ins_in_match) begin
            acc = (m_key.size() < DEPTH);
            net_valid_i = 1'b1;
            net_data_i  = {ikey, idat};
            check("net_ready_match", net_ready_o, acc);
        end
        tick();
        net_valid_i = 1'b0;
        if (!avail) begin
            m_key.delete(idx);
            m_dat.delete(idx);
        end
        if (acc) begin
            m_key.push_back(ikey);
            m_dat.push_back(idat);
        end
        check("wb_latency", wb_valid_o, 1'b1);
        check("wb_data", wb_data_o, {expv, pt});
        check("net_ready_after", net_ready_o, m_key.size() < DEPTH);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("wb_hold_valid", wb_valid_o, 1'b1);
            check("wb_hold_data", wb_data_o, {expv, pt});
        end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        check("wb_done", wb_valid_o, 1'b0);
        check("req_ready_back", req_ready_o, 1'b1);
    endtask

    task automatic drain();
        while (m_key.size() > 0) do_recv(1'b0, 64'd0, 64'd0, 0, 1'b0);
        do_recv(1'b1, 64'd0, 64'd0, 0, 1'b0);
    endtask

    logic [63:0] ones;

    initial begin
        ones        = '1;
        rst_ni      = 1'b0;
        net_valid_i = 1'b0;
        net_data_i  = '0;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        wb_ready_i  = 1'b0;
        tick();
        check("rst_wb_valid", wb_valid_o, 1'b0);
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_net_ready", net_ready_o, 1'b1);
        check("rst_wb_data", wb_data_o, '0);
        rst_ni = 1'b1;
        tick();

        // basic hit, then buffer is empty
        send_msg(mk_key(5, 'h10), 64'hAA);
        do_recv(1'b0, mk_key(5, 'h10), ones, 0, 1'b0);
        do_recv(1'b1, 64'd0, 64'd0, 0, 1'b0);

        // blocking receive satisfied by a later arrival
        do_recv(1'b0, mk_key(7, 0), {32'hFFFF_FFFF, 32'h0}, 5, 1'b0);

        // availability probes
        do_recv(1'b1, mk_key(3, 3), ones, 0, 1'b0);
        send_msg(mk_key(3, 3), 64'h33);
        do_recv(1'b1, mk_key(3, 3), ones, 0, 1'b0);
        drain();

        // oldest-first among equal tags
        send_msg(mk_key(1, 0), 64'hA);
        send_msg(mk_key(2, 0), 64'hB);
        send_msg(mk_key(1, 0), 64'hC);
        do_recv(1'b0, mk_key(1, 0), {32'hFFFF_FFFF, 32'h0}, 0, 1'b0);
        do_recv(1'b0, mk_key(1, 0), {32'hFFFF_FFFF, 32'h0}, 0, 1'b0);
        drain();

        // full buffer: removal does not admit an insert in the same cycle
        for (int i = 0; i < DEPTH; i++) send_msg(mk_key(i, i), 64'(i + 100));
        check("full_net_ready", net_ready_o, 1'b0);
        do_recv(1'b0, mk_key(2, 2), ones, 0, 1'b1);
        // simultaneous insert and remove on a non-full buffer
        do_recv(1'b0, mk_key(0, 0), ones, 0, 1'b1);
        drain();

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            logic [63:0] meta, mask;
            meta = mk_key($urandom_range(0, 3), $urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: mask = ones;
                1: mask = {32'hFFFF_FFFF, 32'h0};
                2: mask = 64'd0;
                default: mask = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 1) == 0 && m_key.size() < DEPTH)
                send_msg(mk_key($urandom_range(0, 3), $urandom_range(0, 1)), {$urandom, $urandom});
            else
                do_recv(1'($urandom_range(0, 1)), meta, mask, $urandom_range(0, 3),
                        1'($urandom_range(0, 1)));
        end
        drain();

        // reset while blocked in MATCH with three entries
        send_msg(mk_key(1, 0), 64'h1);
        send_msg(mk_key(2, 0), 64'h2);
        send_msg(mk_key(3, 0), 64'h3);
        req_valid_i = 1'b1;
        req_data_i  = {1'b0, mk_key(9, 0), ones, 16'h5A5A};
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        check("match_blocked", wb_valid_o, 1'b0);
        rst_ni = 1'b0;
        #2;
        check("mid_rst_wb_valid", wb_valid_o, 1'b0);
        check("mid_rst_req_ready", req_ready_o, 1'b1);
        check("mid_rst_net_ready", net_ready_o, 1'b1);
        check("mid_rst_wb_data", wb_data_o, '0);
        tick();
        rst_ni = 1'b1;
        m_key.delete();
        m_dat.delete();
        tick();
        check("post_rst_wb_valid", wb_valid_o, 1'b0);
        check("post_rst_req_ready", req_ready_o, 1'b1);
        do_recv(1'b1, 64'd0, 64'd0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
